// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: IF/ID stage register and fetch FSM states.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    logic        valid_s;
  } if_id_stage_reg_t;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [3:0] IMEM_RMASK_WORD = 4'hf;
  localparam logic [3:0] IMEM_RMASK_NONE = 4'h0;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: fetch drives the request, memory returns a one-cycle response.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_addr,
    output imem_rmask,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_addr,
    input  imem_rmask,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/fetch_stage.sv
// rv32i instruction fetch: owns PC, retire order and the IF/ID register; one request in flight.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [31:0]          redirect_pc_i,
  input  logic [63:0]          redirect_order_i,
  output if_id_stage_reg_t     if_id_o,
  output logic [31:0]          inst_o,
  output logic                 imem_stall_o
);

  fetch_state_t     r_state, w_state_next;
  logic [31:0]      r_pc, w_pc_next;
  logic [63:0]      r_order, w_order_next;
  logic [31:0]      r_hold_inst, w_hold_inst_next;
  logic [31:0]      r_hold_pc, w_hold_pc_next;
  if_id_stage_reg_t r_if_id, w_if_id_next;
  logic [31:0]      r_inst, w_inst_next;

  logic             w_issue;
  logic             w_deliver;
  logic [31:0]      w_fetch_pc;
  logic [31:0]      w_fetch_inst;

  // Request issue; resp feeds straight through so back-to-back fetch needs no idle cycle.
  // Gated by rst_n so no request leaks out while reset is held.
  always_comb begin
    w_issue = rst_n && !flush_i &&
              ((r_state == FETCH) || ((r_state == WAIT) && imem.imem_resp && !stall_i));
  end

  assign imem.imem_rmask = w_issue ? IMEM_RMASK_WORD : IMEM_RMASK_NONE;
  // In WAIT the new request follows the one just answered.
  assign imem.imem_addr  = (r_state == WAIT) ? (r_pc + 32'd4) : r_pc;
  assign imem_stall_o    = ((r_state == WAIT) && !imem.imem_resp) || (r_state == DRAIN);
  assign if_id_o         = r_if_id;
  assign inst_o          = r_inst;

  // Next-state, PC/order bookkeeping and IF/ID load/hold/bubble selection.
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_order_next     = r_order;
    w_hold_inst_next = r_hold_inst;
    w_hold_pc_next   = r_hold_pc;
    w_if_id_next     = r_if_id;
    w_inst_next      = r_inst;
    w_deliver        = 1'b0;
    w_fetch_pc       = r_pc;
    w_fetch_inst     = imem.imem_rdata;

    if (flush_i) begin
      w_pc_next            = redirect_pc_i;
      w_order_next         = redirect_order_i;
      w_if_id_next.valid_s = 1'b0;
      w_hold_inst_next     = '0;
      w_hold_pc_next       = '0;
      // An unanswered request must still be drained before refetching.
      w_state_next = (((r_state == WAIT) || (r_state == DRAIN)) && !imem.imem_resp) ?
                     DRAIN : FETCH;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (w_issue) w_state_next = WAIT;
        end
        WAIT: begin
          if (imem.imem_resp) begin
            w_pc_next = r_pc + 32'd4;
            if (stall_i) begin
              w_state_next     = HOLD;
              w_hold_inst_next = imem.imem_rdata;
              w_hold_pc_next   = r_pc;
            end else begin
              w_deliver = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            w_state_next = FETCH;
            w_deliver    = 1'b1;
            w_fetch_pc   = r_hold_pc;
            w_fetch_inst = r_hold_inst;
          end
        end
        DRAIN: begin
          if (imem.imem_resp) w_state_next = FETCH;
        end
      endcase

      if (w_deliver) begin
        w_if_id_next.pc_s      = w_fetch_pc;
        w_if_id_next.pc_next_s = w_fetch_pc + 32'd4;
        w_if_id_next.order_s   = r_order;
        w_if_id_next.valid_s   = 1'b1;
        w_inst_next            = w_fetch_inst;
        w_order_next           = r_order + 64'd1;
      end else if (!stall_i) begin
        w_if_id_next.valid_s = 1'b0;
      end
    end
  end

  // State and datapath registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_order     <= '0;
      r_hold_inst <= '0;
      r_hold_pc   <= '0;
      r_if_id     <= '0;
      r_inst      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_order     <= w_order_next;
      r_hold_inst <= w_hold_inst_next;
      r_hold_pc   <= w_hold_pc_next;
      r_if_id     <= w_if_id_next;
      r_inst      <= w_inst_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, stream-level reference, directed scenarios.
module tb_fetch_stage;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int NS = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [31:0]      redirect_pc_i = '0;
  logic [63:0]      redirect_order_i = '0;
  if_id_stage_reg_t if_id_o;
  logic [31:0]      inst_o;
  logic             imem_stall_o;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem_bus),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_pc_i    (redirect_pc_i),
    .redirect_order_i (redirect_order_i),
    .if_id_o          (if_id_o),
    .inst_o           (inst_o),
    .imem_stall_o     (imem_stall_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_del = 0;

  // Memory model and stream-level expectations.
  int               mem_lat = 1;
  logic             mem_busy, mem_stale;
  logic [31:0]      mem_addr;
  int               mem_due;
  logic             plan_resp, plan_stale, cur_stale;
  logic [31:0]      plan_addr;
  logic [31:0]      exp_req, exp_pc;
  logic [63:0]      exp_order;
  logic             prev_stall, prev_flush;
  if_id_stage_reg_t prev_ifid;
  logic [31:0]      prev_inst;

  // Per-cycle samples for hand-computed literal checks.
  logic [3:0]  s_rmask [NS];
  logic [31:0] s_addr  [NS];
  logic        s_valid [NS];
  logic [63:0] s_order [NS];
  logic [31:0] s_pc    [NS];
  logic [31:0] s_inst  [NS];
  logic        s_stall [NS];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5a5a5a5a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic model_clear();
    exp_req    = RESET_PC;
    exp_pc     = RESET_PC;
    exp_order  = '0;
    mem_busy   = 1'b0;
    mem_stale  = 1'b0;
    mem_addr   = '0;
    mem_due    = 0;
    plan_resp  = 1'b0;
    plan_stale = 1'b0;
    plan_addr  = '0;
    cur_stale  = 1'b0;
    prev_stall = 1'b0;
    prev_flush = 1'b0;
    prev_ifid  = '0;
    prev_inst  = '0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    imem_bus.imem_resp  = 1'b0;
    imem_bus.imem_rdata = '0;
  endtask

  // Compare DUT against the stream model once per cycle, then plan the next memory response.
  task automatic compare();
    logic [3:0]  rmask;
    logic [31:0] addr;
    rmask = imem_bus.imem_rmask;
    addr  = imem_bus.imem_addr;
    if (cyc < NS) begin
      s_rmask[cyc] = rmask;
      s_addr[cyc]  = addr;
      s_valid[cyc] = if_id_o.valid_s;
      s_order[cyc] = if_id_o.order_s;
      s_pc[cyc]    = if_id_o.pc_s;
      s_inst[cyc]  = inst_o;
      s_stall[cyc] = imem_stall_o;
    end

    chk("rmask_legal", 64'(rmask == 4'h0 || rmask == 4'hf), 64'd1);
    chk("imem_stall", 64'(imem_stall_o), 64'(mem_busy || cur_stale));
    if (flush_i) chk("no_issue_on_flush", 64'(rmask), 64'd0);
    if (rmask == 4'hf) begin
      chk("single_outstanding", 64'(mem_busy), 64'd0);
      chk("req_addr", 64'(addr), 64'(exp_req));
      mem_busy  = 1'b1;
      mem_stale = 1'b0;
      mem_addr  = addr;
      mem_due   = cyc + mem_lat;
      exp_req   = exp_req + 32'd4;
    end
    if (flush_i) begin
      exp_req = redirect_pc_i;
      if (mem_busy) mem_stale = 1'b1;
    end

    if (prev_flush) begin
      chk("valid_after_flush", 64'(if_id_o.valid_s), 64'd0);
    end else if (prev_stall) begin
      chk("hold_valid", 64'(if_id_o.valid_s), 64'(prev_ifid.valid_s));
      chk("hold_pc", 64'(if_id_o.pc_s), 64'(prev_ifid.pc_s));
      chk("hold_order", if_id_o.order_s, prev_ifid.order_s);
      chk("hold_inst", 64'(inst_o), 64'(prev_inst));
    end else if (if_id_o.valid_s) begin
      chk("deliver_pc", 64'(if_id_o.pc_s), 64'(exp_pc));
      chk("deliver_pc_next", 64'(if_id_o.pc_next_s), 64'(exp_pc + 32'd4));
      chk("deliver_order", if_id_o.order_s, exp_order);
      chk("deliver_inst", 64'(inst_o), 64'(word(exp_pc)));
      exp_pc    = exp_pc + 32'd4;
      exp_order = exp_order + 64'd1;
      n_del++;
    end
    if (flush_i) begin
      exp_pc    = redirect_pc_i;
      exp_order = redirect_order_i;
    end

    prev_flush = flush_i;
    prev_stall = stall_i;
    prev_ifid  = if_id_o;
    prev_inst  = inst_o;

    plan_resp = mem_busy && (mem_due == cyc + 1);
    if (plan_resp) begin
      plan_addr  = mem_addr;
      plan_stale = mem_stale;
      mem_busy   = 1'b0;
      mem_stale  = 1'b0;
    end
  endtask

  // Drive one cycle's inputs (called just after the rising edge) and check at the falling edge.
  task automatic apply(input logic st, input logic fl, input logic [31:0] rpc,
                       input logic [63:0] rord);
    stall_i          = st;
    flush_i          = fl;
    redirect_pc_i    = rpc;
    redirect_order_i = rord;
    imem_bus.imem_resp  = plan_resp;
    imem_bus.imem_rdata = plan_resp ? word(plan_addr) : 32'h0bad0bad;
    cur_stale = plan_resp && plan_stale;
    plan_resp = 1'b0;
    @(negedge clk);
    compare();
    cyc++;
  endtask

  task automatic step(input logic st, input logic fl, input logic [31:0] rpc,
                      input logic [63:0] rord);
    @(posedge clk);
    #1;
    apply(st, fl, rpc, rord);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 64'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rmask"}, 64'(imem_bus.imem_rmask), 64'd0);
    chk({tag, "_valid"}, 64'(if_id_o.valid_s), 64'd0);
    chk({tag, "_pc"}, 64'(if_id_o.pc_s), 64'd0);
    chk({tag, "_pc_next"}, 64'(if_id_o.pc_next_s), 64'd0);
    chk({tag, "_order"}, if_id_o.order_s, 64'd0);
    chk({tag, "_inst"}, 64'(inst_o), 64'd0);
    chk({tag, "_imem_stall"}, 64'(imem_stall_o), 64'd0);
  endtask

  // Assert reset in the second half of a cycle; outputs must clear without a clock edge.
  task automatic reset_midcycle(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_clear();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_rmask_held"}, 64'(imem_bus.imem_rmask), 64'd0);
    end
  endtask

  task automatic release_reset(input int lat);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mem_lat = lat;
    model_clear();
    cyc   = 0;
    n_del = 0;
    apply(1'b0, 1'b0, 32'h0, 64'h0);
  endtask

  logic [15:0] stall_pat;

  initial begin
    model_clear();
    #1;
    check_reset_outputs("por");
    @(posedge clk);

    // Zero-wait memory, then a 3-cycle stall landing on a response.
    release_reset(1);
    idle(4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 64'h0);
    idle(4);
    chk("t1_c0_rmask", 64'(s_rmask[0]), 64'hf);
    chk("t1_c0_addr", 64'(s_addr[0]), 64'h1eceb000);
    chk("t1_c1_addr", 64'(s_addr[1]), 64'h1eceb004);
    chk("t1_c1_valid", 64'(s_valid[1]), 64'd0);
    chk("t1_c2_valid", 64'(s_valid[2]), 64'd1);
    chk("t1_c2_order", s_order[2], 64'd0);
    chk("t1_c2_inst", 64'(s_inst[2]), 64'h4494ea5a);
    chk("t1_c3_order", s_order[3], 64'd1);
    chk("t1_c4_order", s_order[4], 64'd2);
    chk("t1_c5_rmask", 64'(s_rmask[5]), 64'd0);
    chk("t1_c6_rmask", 64'(s_rmask[6]), 64'd0);
    chk("t1_c6_order", s_order[6], 64'd3);
    chk("t1_c8_rmask", 64'(s_rmask[8]), 64'd0);
    chk("t1_c9_valid", 64'(s_valid[9]), 64'd1);
    chk("t1_c9_order", s_order[9], 64'd4);
    chk("t1_c9_pc", 64'(s_pc[9]), 64'h1eceb010);
    chk("t1_c9_addr", 64'(s_addr[9]), 64'h1eceb014);
    chk("t1_c11_order", s_order[11], 64'd5);
    chk("t1_deliveries", 64'(n_del), 64'd6);

    // 3-cycle memory latency: request every 3 cycles, 2 stall cycles each.
    reset_midcycle("rst_t2");
    release_reset(3);
    idle(11);
    begin
      int nreq, nstall;
      nreq = 0;
      nstall = 0;
      for (int i = 0; i < 12; i++) begin
        if (s_rmask[i] == 4'hf) nreq++;
        if (s_stall[i]) nstall++;
      end
      chk("t2_requests", 64'(nreq), 64'd4);
      chk("t2_stall_cycles", 64'(nstall), 64'd8);
    end
    chk("t2_c3_addr", 64'(s_addr[3]), 64'h1eceb004);
    chk("t2_c9_addr", 64'(s_addr[9]), 64'h1eceb00c);
    chk("t2_deliveries", 64'(n_del), 64'd3);
    chk("t2_c10_order", s_order[10], 64'd2);

    // Mixed stalls plus one redirect, checked by the stream model only.
    stall_pat = 16'b0110_0010_1100_0100;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) step(stall_pat[i % 16], 1'b1, 32'h1eceb300, 64'd100);
      else step(stall_pat[i % 16], 1'b0, 32'h0, 64'h0);
    end
    idle(8);

    // Flush while waiting: late response is drained and discarded.
    reset_midcycle("rst_t4");
    release_reset(3);
    step(1'b0, 1'b1, 32'h1eceb100, 64'd7);
    idle(7);
    chk("t4_c1_rmask", 64'(s_rmask[1]), 64'd0);
    chk("t4_c2_valid", 64'(s_valid[2]), 64'd0);
    chk("t4_c2_stall", 64'(s_stall[2]), 64'd1);
    chk("t4_c3_rmask", 64'(s_rmask[3]), 64'd0);
    chk("t4_c3_stall", 64'(s_stall[3]), 64'd1);
    chk("t4_c4_rmask", 64'(s_rmask[4]), 64'hf);
    chk("t4_c4_addr", 64'(s_addr[4]), 64'h1eceb100);
    chk("t4_c4_valid", 64'(s_valid[4]), 64'd0);
    chk("t4_c8_valid", 64'(s_valid[8]), 64'd1);
    chk("t4_c8_order", s_order[8], 64'd7);
    chk("t4_c8_pc", 64'(s_pc[8]), 64'h1eceb100);

    // Flush coincident with response and stall.
    reset_midcycle("rst_t5");
    release_reset(1);
    idle(2);
    step(1'b1, 1'b1, 32'h1eceb200, 64'd20);
    idle(3);
    chk("t5_c3_valid", 64'(s_valid[3]), 64'd1);
    chk("t5_c3_rmask", 64'(s_rmask[3]), 64'd0);
    chk("t5_c4_valid", 64'(s_valid[4]), 64'd0);
    chk("t5_c4_rmask", 64'(s_rmask[4]), 64'hf);
    chk("t5_c4_addr", 64'(s_addr[4]), 64'h1eceb200);
    chk("t5_c4_stall", 64'(s_stall[4]), 64'd0);
    chk("t5_c6_order", s_order[6], 64'd20);
    chk("t5_c6_pc", 64'(s_pc[6]), 64'h1eceb200);

    // Reset while in WAIT, then restart.
    reset_midcycle("rst_t6a");
    release_reset(3);
    idle(1);
    reset_midcycle("rst_wait");
    release_reset(1);
    idle(3);
    chk("t6a_c0_addr", 64'(s_addr[0]), 64'(RESET_PC));
    chk("t6a_c2_order", s_order[2], 64'd0);
    chk("t6a_c2_pc", 64'(s_pc[2]), 64'(RESET_PC));

    // Reset while in HOLD with valid data in IF/ID, then restart.
    reset_midcycle("rst_t6b");
    release_reset(1);
    idle(2);
    step(1'b1, 1'b0, 32'h0, 64'h0);
    step(1'b1, 1'b0, 32'h0, 64'h0);
    chk("t6b_c4_valid", 64'(s_valid[4]), 64'd1);
    reset_midcycle("rst_hold");
    release_reset(1);
    idle(3);
    chk("t6b_c0_addr", 64'(s_addr[0]), 64'(RESET_PC));
    chk("t6b_c2_order", s_order[2], 64'd0);
    chk("t6b_c2_pc", 64'(s_pc[2]), 64'(RESET_PC));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
